// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: sizing defaults and FSM state encoding.
package inst_loader_pkg;

    localparam int INST_DEPTH_DEF = 64;
    localparam int ADDR_W_DEF     = 6;

    typedef enum logic [2:0] {
        LDR_HDR_LO  = 3'd0,
        LDR_HDR_HI  = 3'd1,
        LDR_PAYLOAD = 3'd2,
        LDR_CHECK   = 3'd3,
        LDR_DONE    = 3'd4,
        LDR_ERROR   = 3'd5
    } ldr_state_e;

    // The loader still wants bytes while the frame is incomplete.
    function automatic logic ldr_is_busy(ldr_state_e s);
        return (s == LDR_HDR_LO) || (s == LDR_HDR_HI) || (s == LDR_PAYLOAD) || (s == LDR_CHECK);
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader, bundled as one interface.
interface inst_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/inst_loader_word_packer.sv
// Assembles little-endian 32-bit words from accepted payload bytes; flags the 4th byte of each word.
module ldr_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_q;
    logic [23:0] shreg_q;

    // Only the first three bytes need storage; the 4th is merged combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q  <= 2'd0;
            shreg_q <= 24'd0;
        end else if (clear_i) begin
            lane_q  <= 2'd0;
            shreg_q <= 24'd0;
        end else if (byte_valid_i) begin
            lane_q  <= lane_q + 2'd1;
            shreg_q <= {byte_i, shreg_q[23:8]};
        end
    end

    assign word_valid_o = byte_valid_i && (lane_q == 2'd3);
    assign word_o       = {byte_i, shreg_q};

endmodule

// File: rtl/inst_loader.sv
// Boot-time program loader: frames a byte stream into instruction memory and locks once the image verifies.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int INST_DEPTH = INST_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    inst_loader_if.slave      bus,
    output logic              lock,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    ldr_state_e        state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [7:0]        xor_q, xor_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              accept;
    logic              pack_valid;
    logic              word_valid;
    logic [31:0]       word;
    logic [15:0]       hdr_count;

    assign busy         = ldr_is_busy(state_q);
    assign lock         = (state_q == LDR_DONE);
    assign err          = (state_q == LDR_ERROR);
    assign words_loaded = words_q;

    assign bus.in_ready   = busy && !start;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;

    assign accept     = bus.in_valid && bus.in_ready;
    assign pack_valid = accept && (state_q == LDR_PAYLOAD);
    assign hdr_count  = {bus.in_data, count_q[7:0]};

    ldr_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start),
        .byte_valid_i (pack_valid),
        .byte_i       (bus.in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LDR_HDR_LO;
            count_q <= 16'd0;
            words_q <= '0;
            xor_q   <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            words_q <= words_d;
            xor_q   <= xor_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // start wins over any byte; a write strobe already registered still shows for its one cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        words_d = words_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (start) begin
            state_d = LDR_HDR_LO;
            count_d = 16'd0;
            words_d = '0;
            xor_d   = 8'd0;
        end else if (accept) begin
            case (state_q)
                LDR_HDR_LO: begin
                    count_d[7:0] = bus.in_data;
                    xor_d        = xor_q ^ bus.in_data;
                    state_d      = LDR_HDR_HI;
                end
                LDR_HDR_HI: begin
                    count_d = hdr_count;
                    xor_d   = xor_q ^ bus.in_data;
                    if (hdr_count > 16'(INST_DEPTH)) begin
                        state_d = LDR_ERROR;
                    end else if (hdr_count == 16'd0) begin
                        state_d = LDR_CHECK;
                    end else begin
                        state_d = LDR_PAYLOAD;
                    end
                end
                LDR_PAYLOAD: begin
                    xor_d = xor_q ^ bus.in_data;
                    if (word_valid) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_W-1:0];
                        wdata_d = word;
                        words_d = words_q + 1'b1;
                        if ((16'(words_q) + 16'd1) == count_q) begin
                            state_d = LDR_CHECK;
                        end
                    end
                end
                LDR_CHECK: begin
                    state_d = (xor_q == bus.in_data) ? LDR_DONE : LDR_ERROR;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

endmodule
